// File: rtl/mult_if.sv
// Decode-side handshake and register-file write bundle for the iterative multiplier.
interface mult_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             is_signed;
  logic             accumulate;
  logic             busy;
  logic             done;
  logic             write_enable;
  logic [1:0]       mul;
  logic [WIDTH-1:0] write_data_1;
  logic [WIDTH-1:0] write_data_2;

  modport master (
    output start, op_a, op_b, is_signed, accumulate,
    input  busy, done, write_enable, mul, write_data_1, write_data_2
  );

  modport slave (
    input  start, op_a, op_b, is_signed, accumulate,
    output busy, done, write_enable, mul, write_data_1, write_data_2
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for MULT/MULTU/MADD/MADDU, writing hi/lo to the register file.
// Define EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start, operands latched on accept
// RUN   | one shift-add iteration per clock
// FIX   | apply sign correction, register hi/lo
// DONE  | one-cycle write strobe to the register file
module mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic   clk,
  input  logic   rst,
  mult_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             acc_l_q, acc_l_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]    result;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    acc_l_d  = acc_l_q;
    lo_d     = lo_q;
    hi_d     = hi_q;

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    abs_a  = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    abs_b  = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    result = neg_q ? (~prod_q + 1'b1) : prod_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          neg_d    = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          acc_l_d  = bus.accumulate;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
`ifdef EARLY_TERM_EN
        if (mplier_q == '0) begin
          state_d = S_FIX;
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          // Last set bit consumed this edge: skip the empty iteration that would follow.
          if (cnt_q == LAST_ITER || mplier_q[WIDTH-1:1] == '0) state_d = S_FIX;
        end
`else
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
`endif
      end
      S_FIX: begin
        lo_d    = result[WIDTH-1:0];
        hi_d    = result[PW-1:WIDTH];
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      acc_l_q  <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      acc_l_q  <= acc_l_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.write_enable = (state_q == S_DONE);
  assign bus.mul          = (state_q == S_DONE) ? (acc_l_q ? 2'd2 : 2'd1) : 2'd0;
  assign bus.write_data_1 = lo_q;
  assign bus.write_data_2 = hi_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed table, random ops vs. arithmetic model, corner sequences.
module tb_mult_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mult_if #(.WIDTH(32)) bus();

  mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    bit          acc;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Edges after the accepting edge E until done is visible.
  function automatic int exp_lat(input logic [31:0] b, input bit s);
`ifdef EARLY_TERM_EN
    logic [31:0] ab;
    int nb;
    ab = (s && b[31]) ? (32'd0 - b) : b;
    nb = 0;
    for (int i = 0; i < 32; i++) if (ab[i]) nb = i + 1;
    return ((nb == 0) ? 1 : nb) + 1;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit acc);
    @(negedge clk);
    bus.op_a       = a;
    bus.op_b       = b;
    bus.is_signed  = s;
    bus.accumulate = acc;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Scramble operands to prove they are not re-sampled mid-operation.
    bus.op_a       = $urandom;
    bus.op_b       = $urandom;
    bus.is_signed  = 1'($urandom_range(0, 1));
    bus.accumulate = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int n, output bit ok);
    int i;
    ok = 1'b0;
    n  = 0;
    i  = 0;
    while (!ok && i < 100) begin
      @(posedge clk);
      #1;
      i++;
      if (bus.done) begin
        ok = 1'b1;
        n  = i;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", i);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input bit acc, input logic [63:0] exp_prod);
    int n;
    bit ok;
    issue(a, b, s, acc);
    wait_done(n, ok);
    if (ok) begin
      chk({name, "_latency"}, 64'(n), 64'(exp_lat(b, s)));
      chk({name, "_lo"}, 64'(bus.write_data_1), 64'(exp_prod[31:0]));
      chk({name, "_hi"}, 64'(bus.write_data_2), 64'(exp_prod[63:32]));
      chk({name, "_mul"}, 64'(bus.mul), acc ? 64'd2 : 64'd1);
      chk({name, "_we"}, 64'(bus.write_enable), 64'd1);
      chk({name, "_busy"}, 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1;
      chk({name, "_done_drop"}, 64'(bus.done), 64'd0);
      chk({name, "_mul_idle"}, 64'(bus.mul), 64'd0);
      chk({name, "_busy_idle"}, 64'(bus.busy), 64'd0);
      chk({name, "_lo_hold"}, 64'(bus.write_data_1), 64'(exp_prod[31:0]));
    end
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  saw_done;
    logic [31:0] ra, rb;
    bit  rs, racc;

    checks = 0;
    errors = 0;
    tbl[0] = '{32'd7,        32'd6,        1'b0, 1'b0, 32'd42,        32'd0};
    tbl[1] = '{32'hFFFFFFFD, 32'd5,        1'b1, 1'b0, 32'hFFFFFFF1,  32'hFFFFFFFF};
    tbl[2] = '{32'hFFFFFFFD, 32'd5,        1'b0, 1'b0, 32'hFFFFFFF1,  32'h00000004};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000001,  32'hFFFFFFFE};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000,  32'h40000000};
    tbl[5] = '{32'h80000000, 32'd1,        1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF};
    tbl[6] = '{32'd5,        32'd0,        1'b1, 1'b1, 32'd0,         32'd0};
    tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd1,         32'd0};
    tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000,  32'h40000000};
    tbl[9] = '{32'd12345,    32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFCFC7,  32'hFFFFFFFF};

    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.is_signed  = 1'b0;
    bus.accumulate = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_we", 64'(bus.write_enable), 64'd0);
    chk("reset_mul", 64'(bus.mul), 64'd0);
    chk("reset_wd1", 64'(bus.write_data_1), 64'd0);
    chk("reset_wd2", 64'(bus.write_data_2), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].acc,
             {tbl[i].hi, tbl[i].lo});

    for (int i = 0; i < 20; i++) begin
      ra   = $urandom;
      rb   = $urandom >> $urandom_range(0, 31);
      rs   = 1'($urandom_range(0, 1));
      racc = 1'($urandom_range(0, 1));
      if (rs && $urandom_range(0, 1) == 1) rb = 32'd0 - rb;
      run_op($sformatf("rnd%0d", i), ra, rb, rs, racc, model(ra, rb, rs));
    end

    // Second start at E+5 must be ignored.
    issue(32'd11, 32'd13, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd200;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n, ok);
    if (ok) begin
      chk("b2b_latency", 64'(n + 5), 64'(exp_lat(32'd13, 1'b0)));
      chk("b2b_lo", 64'(bus.write_data_1), 64'd143);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("b2b_no_second_op", 64'(saw_done), 64'd0);

    // start held through DONE is accepted only in the following IDLE cycle.
    issue(32'd9, 32'd9, 1'b0, 1'b0);
    wait_done(n, ok);
    if (ok) begin
      chk("held_first_lo", 64'(bus.write_data_1), 64'd81);
      bus.op_a       = 32'd4;
      bus.op_b       = 32'd5;
      bus.is_signed  = 1'b0;
      bus.accumulate = 1'b1;
      bus.start      = 1'b1;
      @(posedge clk);
      #1;
      chk("held_idle_busy", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("held_accept_busy", 64'(bus.busy), 64'd1);
      wait_done(n, ok);
      if (ok) begin
        chk("held_latency", 64'(n), 64'(exp_lat(32'd5, 1'b0)));
        chk("held_lo", 64'(bus.write_data_1), 64'd20);
        chk("held_mul", 64'(bus.mul), 64'd2);
      end
      @(posedge clk);
      #1;
    end

    // Reset at E+10 aborts without a write strobe.
    issue(32'd77, 32'd3, 1'b1, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_mul", 64'(bus.mul), 64'd0);
    chk("abort_wd", {bus.write_data_2, bus.write_data_1}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.write_enable) saw_done = 1'b1;
    end
    chk("abort_no_strobe", 64'(saw_done), 64'd0);
    run_op("after_abort", 32'd2, 32'd3, 1'b0, 1'b0, 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
